// File: rtl/stage_3.sv
// stage_3: arithmetic-coder low register and bit counter. Emits pre-carry words
// (bit 8 is a pending carry) for each symbol, plus the final bits on flush.
module stage_3 #(
    parameter int RANGE_WIDTH = 16,
    parameter int D_SIZE      = 5,
    parameter int LOW_WIDTH   = 24,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [RANGE_WIDTH:0]   u,
    input  logic [RANGE_WIDTH:0]   v_bool,
    input  logic [RANGE_WIDTH-1:0] initial_range,
    input  logic [D_SIZE-1:0]      in_d,
    input  logic [1:0]             bool_symbol,
    input  logic                   COMP_mux_1,
    input  logic                   flush,
    output logic                   out_valid,
    output logic [1:0]             out_flag,
    output logic [OUT_WIDTH-1:0]   out_bit_1,
    output logic [OUT_WIDTH-1:0]   out_bit_2,
    output logic                   out_last,
    output logic                   err
);

    localparam int SUM_W = LOW_WIDTH + 1;
    localparam logic signed [5:0] CNT_INIT = -6'sd9;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                 state, state_nx;
    logic [LOW_WIDTH-1:0]   low, low_nx;
    logic signed [5:0]      cnt, cnt_nx;
    logic                   valid_nx, last_nx, err_nx;
    logic [1:0]             flag_nx;
    logic [OUT_WIDTH-1:0]   word1_nx, word2_nx;

    logic [RANGE_WIDTH-1:0] delta;
    logic [SUM_W-1:0]       sum_l, rem_l;
    logic signed [6:0]      s_sym;
    logic [4:0]             c_hi, c_lo;
    logic [1:0]             sym_flag;
    logic [OUT_WIDTH-1:0]   sym_w1, sym_w2;
    logic [LOW_WIDTH-1:0]   sym_low;
    logic signed [5:0]      sym_cnt;

    logic [SUM_W-1:0]       e_val;
    logic signed [6:0]      s_fl;
    logic [1:0]             fl_flag;
    logic [OUT_WIDTH-1:0]   fl_w1, fl_w2;

    logic                   unused_msb;
    assign unused_msb = u[RANGE_WIDTH] ^ v_bool[RANGE_WIDTH];

    function automatic logic [SUM_W-1:0] low_mask(input logic [4:0] c);
        return (SUM_W'(1) << c) - SUM_W'(1);
    endfunction

    function automatic logic [OUT_WIDTH-1:0] take_word(input logic [SUM_W-1:0] x,
                                                       input logic [4:0] c);
        return OUT_WIDTH'(x >> c);
    endfunction

    // cnt stays within -9..-1, so cnt+16 always fits in 7..15
    assign c_hi = cnt[4:0] + 5'd16;
    assign c_lo = c_hi - 5'd8;

    always_comb begin
        delta = '0;
        if (bool_symbol[1]) begin
            if (bool_symbol[0]) delta = initial_range - v_bool[RANGE_WIDTH-1:0];
        end else if (COMP_mux_1) begin
            delta = initial_range - u[RANGE_WIDTH-1:0];
        end
    end

    always_comb begin
        sum_l    = SUM_W'(low) + SUM_W'(delta);
        s_sym    = {cnt[5], cnt} + 7'(in_d);
        rem_l    = sum_l;
        sym_flag = 2'd0;
        sym_w1   = '0;
        sym_w2   = '0;
        sym_cnt  = s_sym[5:0];
        if (!s_sym[6]) begin
            if (s_sym >= 7'sd8) begin
                sym_w1   = take_word(rem_l, c_hi);
                sym_w2   = take_word(rem_l & low_mask(c_hi), c_lo);
                rem_l    = rem_l & low_mask(c_lo);
                sym_flag = 2'd2;
                sym_cnt  = s_sym[5:0] - 6'd16;
            end else begin
                sym_w1   = take_word(rem_l, c_hi);
                rem_l    = rem_l & low_mask(c_hi);
                sym_flag = 2'd1;
                sym_cnt  = s_sym[5:0] - 6'd8;
            end
        end
        sym_low = LOW_WIDTH'(rem_l << in_d);
    end

    // Round low up to the 2^14 grid and set the terminating bit
    always_comb begin
        e_val   = ((SUM_W'(low) + SUM_W'(16'h3FFF)) & ~SUM_W'(16'h3FFF)) | SUM_W'(16'h4000);
        s_fl    = {cnt[5], cnt} + 7'sd10;
        fl_flag = 2'd0;
        fl_w1   = '0;
        fl_w2   = '0;
        if (s_fl > 7'sd0) begin
            fl_w1   = take_word(e_val, c_hi);
            fl_flag = 2'd1;
            if (s_fl > 7'sd8) begin
                fl_w2   = take_word(e_val & low_mask(c_hi), c_lo);
                fl_flag = 2'd2;
            end
        end
    end

    always_comb begin
        state_nx = state;
        low_nx   = low;
        cnt_nx   = cnt;
        valid_nx = 1'b0;
        flag_nx  = 2'd0;
        word1_nx = '0;
        word2_nx = '0;
        last_nx  = 1'b0;
        err_nx   = err;
        case (state)
            RUN: begin
                if (in_valid) begin
                    valid_nx = 1'b1;
                    flag_nx  = sym_flag;
                    word1_nx = sym_w1;
                    word2_nx = sym_w2;
                    low_nx   = sym_low;
                    cnt_nx   = sym_cnt;
                end
                if (flush) state_nx = FLUSH;
            end
            FLUSH: begin
                valid_nx = 1'b1;
                last_nx  = 1'b1;
                flag_nx  = fl_flag;
                word1_nx = fl_w1;
                word2_nx = fl_w2;
                low_nx   = '0;
                cnt_nx   = CNT_INIT;
                state_nx = RUN;
                if (in_valid) err_nx = 1'b1;
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            low       <= '0;
            cnt       <= CNT_INIT;
            out_valid <= 1'b0;
            out_flag  <= 2'd0;
            out_bit_1 <= '0;
            out_bit_2 <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            low       <= low_nx;
            cnt       <= cnt_nx;
            out_valid <= valid_nx;
            out_flag  <= flag_nx;
            out_bit_1 <= word1_nx;
            out_bit_2 <= word2_nx;
            out_last  <= last_nx;
            err       <= err_nx;
        end
    end

endmodule

// File: tb/tb_stage_3.sv
// tb_stage_3: directed vectors for stage_3, checked every cycle against a
// queue-based coder model plus hand-computed literal expectations.
module tb_stage_3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [16:0] u = '0;
    logic [16:0] v_bool = '0;
    logic [15:0] initial_range = '0;
    logic [4:0]  in_d = '0;
    logic [1:0]  bool_symbol = '0;
    logic        COMP_mux_1 = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid, out_last, err;
    logic [1:0]  out_flag;
    logic [15:0] out_bit_1, out_bit_2;

    int n_vec = 0;
    int n_miss = 0;
    bit checking = 1'b0;

    stage_3 dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .u(u), .v_bool(v_bool),
        .initial_range(initial_range), .in_d(in_d), .bool_symbol(bool_symbol),
        .COMP_mux_1(COMP_mux_1), .flush(flush), .out_valid(out_valid),
        .out_flag(out_flag), .out_bit_1(out_bit_1), .out_bit_2(out_bit_2),
        .out_last(out_last), .err(err)
    );

    initial forever #5 clk = ~clk;

    // Reference model: coder state as plain integers, words collected in a queue
    longint m_low = 0;
    int     m_cnt = -9;
    bit     m_pending = 1'b0;
    bit     m_err = 1'b0;
    longint q[$];
    longint lval, e, delta;
    int     s, c, d;
    logic        exp_valid = 1'b0, exp_last = 1'b0;
    logic [1:0]  exp_flag = '0;
    logic [15:0] exp_w1 = '0, exp_w2 = '0;

    function automatic longint pow2(input int k);
        return longint'(1) << k;
    endfunction

    always @(posedge clk or posedge reset) begin
        q.delete();
        exp_valid = 1'b0; exp_last = 1'b0; exp_flag = '0; exp_w1 = '0; exp_w2 = '0;
        if (reset) begin
            m_low = 0; m_cnt = -9; m_pending = 1'b0; m_err = 1'b0;
        end else if (m_pending) begin
            if (in_valid) m_err = 1'b1;
            e = ((m_low + 64'h3FFF) & ~64'h3FFF) | 64'h4000;
            c = m_cnt;
            s = c + 10;
            while (s > 0) begin
                q.push_back(e >> (c + 16));
                e = e % pow2(c + 16);
                s -= 8;
                c -= 8;
            end
            exp_valid = 1'b1; exp_last = 1'b1;
            m_low = 0; m_cnt = -9; m_pending = 1'b0;
        end else begin
            if (in_valid) begin
                if (bool_symbol[1])
                    delta = bool_symbol[0] ? ((longint'(initial_range) - longint'(v_bool[15:0])) & 64'hFFFF) : 0;
                else
                    delta = COMP_mux_1 ? ((longint'(initial_range) - longint'(u[15:0])) & 64'hFFFF) : 0;
                lval = m_low + delta;
                d = int'(in_d);
                s = m_cnt + d;
                if (s < 0) begin
                    m_low = (lval << d) % pow2(24);
                    m_cnt = s;
                end else begin
                    c = m_cnt + 16;
                    if (s >= 8) begin
                        q.push_back(lval >> c);
                        lval = lval % pow2(c);
                        c -= 8;
                    end
                    q.push_back(lval >> c);
                    lval = lval % pow2(c);
                    m_low = (lval << d) % pow2(24);
                    m_cnt = c + d - 24;
                end
                exp_valid = 1'b1;
            end
            if (flush) m_pending = 1'b1;
        end
        exp_flag = 2'(q.size());
        if (q.size() > 0) exp_w1 = 16'(q[0]);
        if (q.size() > 1) exp_w2 = 16'(q[1]);
    end

    task automatic compareField(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic compareNum(input string name, input longint act, input longint expv);
        n_vec++;
        if (act != expv) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            compareField("model out_valid", 16'(out_valid), 16'(exp_valid));
            compareField("model out_flag", 16'(out_flag), 16'(exp_flag));
            compareField("model out_bit_1", out_bit_1, exp_w1);
            compareField("model out_bit_2", out_bit_2, exp_w2);
            compareField("model out_last", 16'(out_last), 16'(exp_last));
            compareField("model err", 16'(err), 16'(m_err));
        end
    end

    // Called at a falling edge; results are visible at the following falling edge
    task automatic applyStimulus(input bit vld, input bit [1:0] bsym, input bit comp,
                                 input bit [15:0] rng, input bit [15:0] uu,
                                 input bit [15:0] vv, input bit [4:0] dd, input bit fl);
        in_valid = vld; bool_symbol = bsym; COMP_mux_1 = comp; initial_range = rng;
        u = {1'b0, uu}; v_bool = {1'b0, vv}; in_d = dd; flush = fl;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; bool_symbol = '0; COMP_mux_1 = 1'b0;
        initial_range = '0; u = '0; v_bool = '0; in_d = '0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input bit vld, input bit [1:0] flg,
                               input bit [15:0] w1, input bit [15:0] w2, input bit lst);
        compareField({tag, " out_valid"}, 16'(out_valid), 16'(vld));
        compareField({tag, " out_flag"}, 16'(out_flag), 16'(flg));
        compareField({tag, " out_bit_1"}, out_bit_1, w1);
        compareField({tag, " out_bit_2"}, out_bit_2, w2);
        compareField({tag, " out_last"}, 16'(out_last), 16'(lst));
    endtask

    task automatic checkModel(input string tag, input longint lo, input int cn);
        compareNum({tag, " model low"}, m_low, lo);
        compareNum({tag, " model cnt"}, longint'(m_cnt), longint'(cn));
    endtask

    task automatic doReset();
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        bit        vld;
        bit [1:0]  bsym;
        bit        comp;
        bit [15:0] rng;
        bit [15:0] uu;
        bit [15:0] vv;
        bit [4:0]  dd;
        bit        fl;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl = '{
            '{1'b1, 2'b00, 1'b1, 16'hC000, 16'h1234, 16'h0000, 5'd0,  1'b0},
            '{1'b1, 2'b11, 1'b0, 16'hA000, 16'h0000, 16'h2000, 5'd15, 1'b0},
            '{1'b1, 2'b01, 1'b0, 16'h8000, 16'h0000, 16'h1000, 5'd7,  1'b0},
            '{1'b1, 2'b00, 1'b1, 16'hFFFF, 16'h0100, 16'h0000, 5'd12, 1'b0},
            '{1'b1, 2'b10, 1'b1, 16'h9000, 16'h0100, 16'h0200, 5'd15, 1'b0},
            '{1'b1, 2'b00, 1'b1, 16'h9000, 16'h0800, 16'h0000, 5'd9,  1'b1},
            '{1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 5'd0,  1'b0},
            '{1'b1, 2'b11, 1'b0, 16'h7000, 16'h0000, 16'h3000, 5'd14, 1'b0},
            '{1'b1, 2'b00, 1'b0, 16'h8000, 16'h4000, 16'h0000, 5'd15, 1'b0},
            '{1'b1, 2'b00, 1'b1, 16'hF000, 16'h0010, 16'h0000, 5'd15, 1'b0},
            '{1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 5'd0,  1'b1},
            '{1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 5'd0,  1'b0},
            '{1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 5'd0,  1'b0}
        };

        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        checking = 1'b1;
        checkOutput("reset", 1'b0, 2'd0, 16'h0, 16'h0, 1'b0);
        compareField("reset err", 16'(err), 16'h0);

        $display("[TB] CDF then bool symbol");
        applyStimulus(1'b1, 2'b00, 1'b1, 16'h8000, 16'h6000, 16'h0, 5'd1, 1'b0);
        checkOutput("cdf d1", 1'b1, 2'd0, 16'h0, 16'h0, 1'b0);
        checkModel("cdf d1", 64'h4000, -8);
        applyStimulus(1'b1, 2'b10, 1'b0, 16'h8000, 16'h0, 16'h0, 5'd8, 1'b0);
        checkOutput("bool d8", 1'b1, 2'd1, 16'h0040, 16'h0, 1'b0);
        checkModel("bool d8", 0, -8);

        $display("[TB] carry word and two-word symbol");
        doReset();
        applyStimulus(1'b1, 2'b00, 1'b1, 16'hFFFF, 16'h0001, 16'h0, 5'd15, 1'b0);
        checkOutput("carry", 1'b1, 2'd1, 16'h01FF, 16'h0, 1'b0);
        checkModel("carry", 64'h3F0000, -2);
        applyStimulus(1'b1, 2'b00, 1'b0, 16'h8000, 16'h0, 16'h0, 5'd10, 1'b0);
        checkOutput("two words", 1'b1, 2'd2, 16'h00FC, 16'h0000, 1'b0);
        checkModel("two words", 0, -8);

        $display("[TB] flush after reset");
        doReset();
        applyStimulus(1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 16'h0, 5'd0, 1'b1);
        checkOutput("flush req", 1'b0, 2'd0, 16'h0, 16'h0, 1'b0);
        idleCycle();
        checkOutput("flush empty", 1'b1, 2'd1, 16'h0080, 16'h0, 1'b1);
        checkModel("flush empty", 0, -9);
        idleCycle();
        checkOutput("after flush", 1'b0, 2'd0, 16'h0, 16'h0, 1'b0);

        $display("[TB] flush with pending bits");
        doReset();
        applyStimulus(1'b1, 2'b00, 1'b1, 16'hFFFF, 16'h0001, 16'h0, 5'd15, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 16'h0, 5'd0, 1'b1);
        idleCycle();
        checkOutput("flush FD", 1'b1, 2'd1, 16'h00FD, 16'h0, 1'b1);

        applyStimulus(1'b1, 2'b00, 1'b1, 16'h8000, 16'h7F00, 16'h0, 5'd8, 1'b0);
        checkModel("cnt -1", 64'h10000, -1);
        applyStimulus(1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 16'h0, 5'd0, 1'b1);
        idleCycle();
        checkOutput("flush 2w", 1'b1, 2'd2, 16'h0002, 16'h0080, 1'b1);

        $display("[TB] symbol with flush, then symbol in flush cycle");
        applyStimulus(1'b1, 2'b11, 1'b0, 16'h9000, 16'h0, 16'h1000, 5'd4, 1'b1);
        checkOutput("sym+flush", 1'b1, 2'd0, 16'h0, 16'h0, 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b1, 16'h8000, 16'h1000, 16'h0, 5'd9, 1'b0);
        checkOutput("flush 108", 1'b1, 2'd1, 16'h0108, 16'h0, 1'b1);
        compareField("err set", 16'(err), 16'h1);
        idleCycle();
        checkOutput("dropped", 1'b0, 2'd0, 16'h0, 16'h0, 1'b0);
        compareField("err sticky", 16'(err), 16'h1);

        $display("[TB] asynchronous reset mid-stream");
        applyStimulus(1'b1, 2'b10, 1'b0, 16'h8000, 16'h0, 16'h0, 5'd3, 1'b1);
        checkOutput("pre-reset", 1'b1, 2'd0, 16'h0, 16'h0, 1'b0);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset", 1'b0, 2'd0, 16'h0, 16'h0, 1'b0);
        compareField("async reset err", 16'(err), 16'h0);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        idleCycle();
        checkOutput("flush lost", 1'b0, 2'd0, 16'h0, 16'h0, 1'b0);

        $display("[TB] directed vector table");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].vld, tbl[i].bsym, tbl[i].comp, tbl[i].rng,
                          tbl[i].uu, tbl[i].vv, tbl[i].dd, tbl[i].fl);
        end

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
